// File: rtl/dp_mem_arbiter.sv
// ============================================================================
// Module      : dp_mem_arbiter
// Description : Round-robin arbiter sharing one single-port RAM between two
//               request/grant ports, each with a registered completion return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_mem_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_b_gnt,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_b_rdata
);

    localparam int  c_DEPTH  = 2 ** ADDR_W;
    localparam logic c_LAST_A = 1'b0;
    localparam logic c_LAST_B = 1'b1;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic              r_last;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_commit;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_result;

    // A tie goes to whichever port did not commit most recently.
    assign w_a_gnt  = i_a_req & (~i_b_req | (r_last == c_LAST_B));
    assign w_b_gnt  = i_b_req & (~i_a_req | (r_last == c_LAST_A));
    assign w_commit = w_a_gnt | w_b_gnt;

    assign w_we     = w_b_gnt ? i_b_we    : i_a_we;
    assign w_addr   = w_b_gnt ? i_b_addr  : i_a_addr;
    assign w_wdata  = w_b_gnt ? i_b_wdata : i_a_wdata;

    // Reads return pre-edge contents; writes echo their own data back.
    assign w_result = w_we ? w_wdata : r_mem[w_addr];

    always_ff @(posedge clk) begin
        if (w_commit && w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= c_LAST_B;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_a_gnt;
            r_b_rvalid <= w_b_gnt;
            if (w_a_gnt) begin
                r_a_rdata <= w_result;
                r_last    <= c_LAST_A;
            end
            if (w_b_gnt) begin
                r_b_rdata <= w_result;
                r_last    <= c_LAST_B;
            end
        end
    end

    assign o_a_gnt    = w_a_gnt;
    assign o_b_gnt    = w_b_gnt;
    assign o_a_rvalid = r_a_rvalid;
    assign o_b_rvalid = r_b_rvalid;
    assign o_a_rdata  = r_a_rdata;
    assign o_b_rdata  = r_b_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dp_mem_arbiter.sv
// ============================================================================
// Module      : tb_dp_mem_arbiter
// Description : Directed scoreboard bench for dp_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dp_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [5:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] mdl [int];

    dp_mem_arbiter #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_a_req    (a_req),
        .i_a_we     (a_we),
        .i_a_addr   (a_addr),
        .i_a_wdata  (a_wdata),
        .o_a_gnt    (a_gnt),
        .o_a_rvalid (a_rvalid),
        .o_a_rdata  (a_rdata),
        .i_b_req    (b_req),
        .i_b_we     (b_we),
        .i_b_addr   (b_addr),
        .i_b_wdata  (b_wdata),
        .o_b_gnt    (b_gnt),
        .o_b_rvalid (b_rvalid),
        .o_b_rdata  (b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every rvalid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid) begin
                if (qa.size() == 0) chk("a_unexpected_rvalid", 8'd1, 8'd0);
                else chk("a_rdata", a_rdata, qa.pop_front());
            end
            if (b_rvalid) begin
                if (qb.size() == 0) chk("b_unexpected_rvalid", 8'd1, 8'd0);
                else chk("b_rdata", b_rdata, qb.pop_front());
            end
        end
    end

    task automatic set_a(input logic req, input logic we, input logic [5:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [5:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    // One cycle: check grants, record the expected completion, advance past the edge.
    task automatic step(input logic exp_ag, input logic exp_bg, input bit record);
        #1;
        chk("a_gnt", {7'd0, a_gnt}, {7'd0, exp_ag});
        chk("b_gnt", {7'd0, b_gnt}, {7'd0, exp_bg});
        if (exp_ag) begin
            if (record) qa.push_back(a_we ? a_wdata : mdl[int'(a_addr)]);
            if (a_we) mdl[int'(a_addr)] = a_wdata;
        end
        if (exp_bg) begin
            if (record) qb.push_back(b_we ? b_wdata : mdl[int'(b_addr)]);
            if (b_we) mdl[int'(b_addr)] = b_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        do_reset(3);

        // Reset/idle state
        chk("rst_a_rvalid", {7'd0, a_rvalid}, 8'd0);
        chk("rst_b_rvalid", {7'd0, b_rvalid}, 8'd0);
        chk("rst_a_rdata", a_rdata, 8'h00);
        chk("rst_b_rdata", b_rdata, 8'h00);
        step(0, 0, 1);

        // A alone: write then read back
        set_a(1, 1, 6'd10, 8'hA5); step(1, 0, 1);
        set_a(1, 0, 6'd10, 8'h00); step(1, 0, 1);
        set_a(0, 0, 0, 0);          step(0, 0, 1);

        // Fresh reset: RAM persists, first tie goes to A
        do_reset(2);
        set_a(1, 0, 6'd10, 8'h00);
        set_b(1, 1, 6'd10, 8'h3C); step(1, 0, 1);
        set_a(0, 0, 0, 0);          step(0, 1, 1);
        set_b(0, 0, 0, 0);
        set_a(1, 0, 6'd10, 8'h00); step(1, 0, 1);

        // Preload 0 and 63, leaving B as last winner
        set_a(1, 1, 6'd0, 8'h11);  step(1, 0, 1);
        set_a(0, 0, 0, 0);
        set_b(1, 1, 6'd63, 8'hEE); step(0, 1, 1);

        // Continuous contention: strict alternation
        set_a(1, 0, 6'd0, 8'h00);
        set_b(1, 0, 6'd63, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1);
            step(0, 1, 1);
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step(0, 0, 1);

        // Reset right after B's write commits: completion is discarded
        set_b(1, 1, 6'd5, 8'h77);
        step(0, 1, 0);
        rst_n = 1'b0;
        set_b(0, 0, 0, 0);
        #1;
        chk("midrst_b_rvalid", {7'd0, b_rvalid}, 8'd0);
        chk("midrst_b_rdata", b_rdata, 8'h00);
        @(negedge clk);
        chk("midrst_b_rvalid2", {7'd0, b_rvalid}, 8'd0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        set_a(1, 0, 6'd5, 8'h00);
        set_b(1, 0, 6'd5, 8'h00); step(1, 0, 1);
        set_a(0, 0, 0, 0);          step(0, 1, 1);
        set_b(0, 0, 0, 0);

        // Withdrawn request: make A last, then A loses a tie and drops
        set_a(1, 0, 6'd0, 8'h00);  step(1, 0, 1);
        set_a(1, 1, 6'd10, 8'hFF);
        set_b(1, 0, 6'd63, 8'h00); step(0, 1, 1);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);          step(0, 0, 1);
        step(0, 0, 1);
        set_a(1, 0, 6'd10, 8'h00);
        set_b(1, 0, 6'd10, 8'h00); step(1, 0, 1);
        set_a(0, 0, 0, 0);          step(0, 1, 1);
        set_b(0, 0, 0, 0);
        chk("withdraw_ram_kept", mdl[10], 8'h3C);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", 8'(qa.size()), 8'd0);
        chk("qb_drained", 8'(qb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
